pc_branch_ctrl: RTL and testbench

- Program-counter and branch-resolution stage of the 16-bit single-cycle core.
- Sits upstream of the ALU: it supplies the PC to instruction fetch and consumes the ALU's registered N/Z/V flags to resolve B/BR.
- Handles PCS (return address), HLT (halt state) and fetch stalls, and keeps a retired-instruction counter.

---
 rtl/pc_branch_ctrl_pkg.sv | 29 ++
 rtl/pc_branch_ctrl_br_cond.sv | 28 ++
 rtl/pc_branch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_ctrl_pkg.sv
// Shared encodings for the PC/branch stage: opcodes, condition codes, FSM states
// and the branch-offset helper.
package pc_branch_ctrl_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Branch displacement: sign-extended word offset converted to a byte offset.
  function automatic logic [15:0] branch_offset(input logic [8:0] imm9);
    return {{6{imm9[8]}}, imm9, 1'b0};
  endfunction

endpackage

// File: rtl/pc_branch_ctrl_br_cond.sv
// Condition-code evaluator shared with the ALU flag logic; purely combinational.
module pc_branch_ctrl_br_cond
  import pc_branch_ctrl_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       v_flag,
  output logic       cond
);

  // Map the 3-bit condition code onto the current flag values.
  always_comb begin
    cond = 1'b0;
    case (ccc)
      CC_NE:   cond = !z_flag;
      CC_EQ:   cond = z_flag;
      CC_GT:   cond = !z_flag && !n_flag;
      CC_LT:   cond = n_flag;
      CC_GE:   cond = z_flag || (!z_flag && !n_flag);
      CC_LE:   cond = n_flag || z_flag;
      CC_OV:   cond = v_flag;
      CC_UNC:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program counter, branch resolution, halt state and retired-instruction counter
// of the 16-bit single-cycle core.
module pc_branch_ctrl
  import pc_branch_ctrl_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [15:0]      instr,
  input  logic [15:0]      br_reg,
  input  logic             N_Flag,
  input  logic             Z_Flag,
  input  logic             V_Flag,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_r;
  logic [15:0]      pc_r;
  logic             halted_r;
  logic [CNT_W-1:0] retired_r;

  logic [3:0]  opcode_s;
  logic [2:0]  ccc_s;
  logic [8:0]  imm9_s;
  logic        cond_s;
  logic        exec_s;
  logic [15:0] pc_plus2_s;
  logic [15:0] pc_next_s;

  assign opcode_s   = instr[15:12];
  assign ccc_s      = instr[11:9];
  assign imm9_s     = instr[8:0];
  assign pc_plus2_s = pc_r + 16'h0002;
  assign exec_s     = (state_r == ST_RUN) && !stall;

  pc_branch_ctrl_br_cond u_br_cond (
    .ccc    (ccc_s),
    .n_flag (N_Flag),
    .z_flag (Z_Flag),
    .v_flag (V_Flag),
    .cond   (cond_s)
  );

  // Select the next PC for an executing instruction; BR targets are taken verbatim.
  always_comb begin
    pc_next_s = pc_plus2_s;
    case (opcode_s)
      OP_B: begin
        if (cond_s) begin
          pc_next_s = pc_plus2_s + branch_offset(imm9_s);
        end else begin
          pc_next_s = pc_plus2_s;
        end
      end
      OP_BR: begin
        if (cond_s) begin
          pc_next_s = br_reg;
        end else begin
          pc_next_s = pc_plus2_s;
        end
      end
      OP_HLT:  pc_next_s = pc_r;
      default: pc_next_s = pc_plus2_s;
    endcase
  end

  // Branch-taken indication, suppressed while halted or stalled.
  always_comb begin
    if (exec_s && ((opcode_s == OP_B) || (opcode_s == OP_BR))) begin
      taken = cond_s;
    end else begin
      taken = 1'b0;
    end
  end

  // State, PC and retired counter; HALT is left only through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      pc_r      <= PC_RESET;
      halted_r  <= 1'b0;
      retired_r <= '0;
    end else if (exec_s) begin
      pc_r      <= pc_next_s;
      retired_r <= retired_r + CNT_W'(1'b1);
      if (opcode_s == OP_HLT) begin
        state_r  <= ST_HALT;
        halted_r <= 1'b1;
      end else begin
        state_r  <= state_r;
        halted_r <= halted_r;
      end
    end else begin
      state_r   <= state_r;
      pc_r      <= pc_r;
      halted_r  <= halted_r;
      retired_r <= retired_r;
    end
  end

  assign pc       = pc_r;
  assign pc_plus2 = pc_plus2_s;
  assign halted   = halted_r;
  assign retired  = retired_r;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: reference model feeds a scoreboard
// queue of expected post-edge state, popped by a monitor after each edge.
module tb_pc_branch_ctrl;

  typedef struct {
    logic [15:0] pc;
    logic        halted;
    logic [15:0] retired;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [15:0] instr;
  logic [15:0] br_reg;
  logic        n_flag;
  logic        z_flag;
  logic        v_flag;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic        halted;
  logic [15:0] retired;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_pc;
  logic        m_halt;
  logic [15:0] m_ret;

  pc_branch_ctrl #(.PC_RESET(16'h0000), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .instr    (instr),
    .br_reg   (br_reg),
    .N_Flag   (n_flag),
    .Z_Flag   (z_flag),
    .V_Flag   (v_flag),
    .pc       (pc),
    .pc_plus2 (pc_plus2),
    .taken    (taken),
    .halted   (halted),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] cc, input logic [8:0] imm);
    return {op, cc, imm};
  endfunction

  function automatic logic model_cond(input logic [2:0] cc, input logic n, input logic z, input logic v);
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: pop one expectation per edge while the scoreboard holds entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("pc", {16'h0, pc}, {16'h0, e.pc});
        check_val("halted", {31'h0, halted}, {31'h0, e.halted});
        check_val("retired", {16'h0, retired}, {16'h0, e.retired});
      end
    end
  end

  // One clock of stimulus: immediate checks on combinational outputs, then
  // the model's next state goes to the scoreboard.
  task automatic step(input logic r, input logic s, input logic [15:0] ins,
                      input logic [15:0] br, input logic [2:0] nzv);
    logic [3:0]  op;
    logic        c;
    logic        exp_taken;
    logic [15:0] p2;
    exp_t        e;
    rst = r; stall = s; instr = ins; br_reg = br;
    {n_flag, z_flag, v_flag} = nzv;
    #1;
    op = ins[15:12];
    c  = model_cond(ins[11:9], nzv[2], nzv[1], nzv[0]);
    p2 = m_pc + 16'd2;
    exp_taken = !m_halt && !s && ((op == 4'hC) || (op == 4'hD)) && c;
    if (!r) begin
      check_val("taken", {31'h0, taken}, {31'h0, exp_taken});
      check_val("pc_plus2", {16'h0, pc_plus2}, {16'h0, p2});
    end
    if (r) begin
      m_pc = 16'h0000; m_halt = 1'b0; m_ret = 16'h0000;
    end else if (!m_halt && !s) begin
      m_ret = m_ret + 16'd1;
      case (op)
        4'hC: m_pc = c ? p2 + {{6{ins[8]}}, ins[8:0], 1'b0} : p2;
        4'hD: m_pc = c ? br : p2;
        4'hF: m_halt = 1'b1;
        default: m_pc = p2;
      endcase
    end
    e.pc = m_pc; e.halted = m_halt; e.retired = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic jump_to(input logic [15:0] target);
    step(1'b0, 1'b0, mk(4'hD, 3'd7, 9'h000), target, 3'b000);
  endtask

  task automatic expect_pc(input string tag, input logic [15:0] val);
    check_val(tag, {16'h0, pc}, {16'h0, val});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    m_pc = 16'h0; m_halt = 1'b0; m_ret = 16'h0;
    rst = 1'b1; stall = 1'b0; instr = 16'h0; br_reg = 16'h0;
    n_flag = 1'b0; z_flag = 1'b0; v_flag = 1'b0;
    @(posedge clk);
    #2;
    step(1'b1, 1'b0, 16'h0000, 16'h0, 3'b000);
    expect_pc("reset_pc", 16'h0000);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, mk(4'h1, 3'd0, 9'h000), 16'h0, 3'b000);
    expect_pc("seq_pc", 16'h0006);
    check_val("seq_retired", {16'h0, retired}, 32'd3);

    jump_to(16'h0010);
    step(1'b0, 1'b0, mk(4'hC, 3'd1, 9'h003), 16'h0, 3'b010);
    expect_pc("b_eq_taken", 16'h0018);
    jump_to(16'h0010);
    step(1'b0, 1'b0, mk(4'hC, 3'd1, 9'h003), 16'h0, 3'b000);
    expect_pc("b_eq_not", 16'h0012);

    jump_to(16'h0020);
    step(1'b0, 1'b0, mk(4'hC, 3'd7, 9'h1FE), 16'h0, 3'b000);
    expect_pc("b_neg", 16'h001E);
    jump_to(16'hFFFE);
    step(1'b0, 1'b0, mk(4'hE, 3'd0, 9'h000), 16'h0, 3'b000);
    expect_pc("wrap", 16'h0000);

    step(1'b0, 1'b0, mk(4'hD, 3'd2, 9'h000), 16'h1234, 3'b000);
    expect_pc("br_gt", 16'h1234);
    step(1'b0, 1'b0, mk(4'hD, 3'd2, 9'h000), 16'h1234, 3'b100);
    expect_pc("br_gt_not", 16'h1236);
    step(1'b0, 1'b0, mk(4'hD, 3'd6, 9'h000), 16'h1234, 3'b001);
    expect_pc("br_ov", 16'h1234);
    step(1'b0, 1'b0, mk(4'hD, 3'd7, 9'h000), 16'h1235, 3'b000);
    expect_pc("br_odd", 16'h1235);

    // Sweep every condition code against every flag combination.
    for (int f = 0; f < 8; f++) begin
      for (int cc = 0; cc < 8; cc++) begin
        step(1'b0, 1'b0, mk(4'hC, cc[2:0], 9'h004), 16'h0, f[2:0]);
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(4'hC, 3'd7, 9'h010), 16'h0, 3'b000);
    step(1'b0, 1'b1, mk(4'hF, 3'd0, 9'h000), 16'h0, 3'b000);
    step(1'b0, 1'b0, mk(4'hC, 3'd7, 9'h010), 16'h0, 3'b000);

    jump_to(16'h0040);
    step(1'b0, 1'b0, mk(4'hF, 3'd0, 9'h000), 16'h0, 3'b000);
    expect_pc("hlt_pc", 16'h0040);
    check_val("hlt_flag", {31'h0, halted}, 32'd1);
    step(1'b0, 1'b0, mk(4'hC, 3'd7, 9'h010), 16'h0, 3'b000);
    step(1'b0, 1'b0, mk(4'hD, 3'd7, 9'h000), 16'h5555, 3'b111);
    step(1'b0, 1'b0, mk(4'h2, 3'd0, 9'h000), 16'h0, 3'b000);
    expect_pc("halt_frozen", 16'h0040);

    step(1'b1, 1'b0, 16'h0000, 16'h0, 3'b000);
    expect_pc("rst_from_halt", 16'h0000);
    check_val("rst_halted", {31'h0, halted}, 32'd0);
    step(1'b0, 1'b0, mk(4'h3, 3'd0, 9'h000), 16'h0, 3'b000);
    expect_pc("run_after_rst", 16'h0002);

    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
